// File: rtl/data_mem_lsu.sv
// Data memory with load/store unit: byte/half/word RV32 accesses, configurable wait states,
// req/busy/done handshake and fault reporting for misaligned, out-of-range or illegal accesses.
module data_mem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       readdata,
  output logic              fault
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic              capture, do_access, fault_next;

  logic              cap_we;
  logic [2:0]        cap_funct3;
  logic [IDX_W+1:0]  cap_address;
  logic [31:0]       cap_writedata;

  logic              acc_we;
  logic [2:0]        acc_funct3;
  logic [IDX_W+1:0]  acc_address;
  logic [31:0]       acc_writedata;
  logic [IDX_W-1:0]  word_idx;

  logic              illegal, misaligned, out_of_range, in_fault;
  logic [31:0]       old_word, load_ext, lane_data, merged;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [3:0]        byte_en;

  logic [31:0]          mem [DEPTH_WORDS];
  // Words never stored to read back as their own index; relies on the zero power-up of these flops.
  logic [DEPTH_WORDS-1:0] written;

  assign illegal = we ? (funct3[2] || funct3 == 3'b011)
                      : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  assign misaligned = (funct3[1:0] == 2'b01 && address[0]) ||
                      (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
  assign out_of_range = address[ADDR_W-1:2] >= DEPTH_LIM;
  assign in_fault = illegal || misaligned || out_of_range;

  // A WAIT access works from captured fields; an immediate (LATENCY=0) access uses the live inputs.
  assign acc_we        = (state == WAIT) ? cap_we        : we;
  assign acc_funct3    = (state == WAIT) ? cap_funct3    : funct3;
  assign acc_address   = (state == WAIT) ? cap_address   : address[IDX_W+1:0];
  assign acc_writedata = (state == WAIT) ? cap_writedata : writedata;
  assign word_idx      = acc_address[IDX_W+1:2];

  assign old_word  = written[word_idx] ? mem[word_idx] : 32'(word_idx);
  assign lane_half = acc_address[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    lane_byte = old_word[7:0];
    case (acc_address[1:0])
      2'b01:   lane_byte = old_word[15:8];
      2'b10:   lane_byte = old_word[23:16];
      2'b11:   lane_byte = old_word[31:24];
      default: lane_byte = old_word[7:0];
    endcase
  end

  always_comb begin
    load_ext = old_word;
    case (acc_funct3)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = old_word;
    endcase
  end

  always_comb begin
    byte_en   = 4'b1111;
    lane_data = acc_writedata;
    case (acc_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << acc_address[1:0];
        lane_data = {4{acc_writedata[7:0]}};
      end
      2'b01: begin
        byte_en   = acc_address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_writedata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = acc_writedata;
      end
    endcase
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    do_access  = 1'b0;
    fault_next = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (req) begin
          capture = 1'b1;
          if (in_fault) begin
            state_next = DONE;
            fault_next = 1'b1;
          end else if (LATENCY == 0) begin
            state_next = DONE;
            do_access  = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          state_next = DONE;
          do_access  = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= 4'd0;
      cap_we        <= 1'b0;
      cap_funct3    <= 3'd0;
      cap_address   <= '0;
      cap_writedata <= 32'd0;
      fault         <= 1'b0;
      readdata      <= 32'd0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      fault    <= fault_next;
      readdata <= (do_access && !acc_we) ? load_ext : 32'd0;
      if (capture) begin
        cap_we        <= we;
        cap_funct3    <= funct3;
        cap_address   <= address[IDX_W+1:0];
        cap_writedata <= writedata;
      end
    end
  end

  // Array is deliberately outside the reset domain; a store held in reset never commits.
  always_ff @(posedge clk) begin
    if (rst && do_access && acc_we) begin
      mem[word_idx]     <= merged;
      written[word_idx] <= 1'b1;
    end
  end

  assign busy = (state == WAIT);
  assign done = (state == DONE);

endmodule
